// File: rtl/regfile_wb_queue_if.sv
// Bundle of the write-back queue's producer handshakes, retire port, bypass query and status.
// master = the pipeline side driving producers/controls, slave = the queue itself.
interface regfile_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;

  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [DW-1:0]   mem_data;

  logic            stall;
  logic            flush;

  logic            WE3;
  logic [AW-1:0]   A3;
  logic [DW-1:0]   WD3;

  logic [AW-1:0]   q_addr;
  logic            q_hit;
  logic [DW-1:0]   q_data;

  logic [2**AW-1:0] busy;
  logic [CW-1:0]    count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output stall, flush, q_addr,
    input  alu_ready, mem_ready,
    input  WE3, A3, WD3,
    input  q_hit, q_data, busy, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  stall, flush, q_addr,
    output alu_ready, mem_ready,
    output WE3, A3, WD3,
    output q_hit, q_data, busy, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port: merges ALU and load
// results, retires one per cycle in order, and exposes pending bits plus a bypass read.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**AW;

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;

  logic          full;
  logic          empty;
  logic          mem_ready;
  logic          alu_ready;
  logic          mem_take;
  logic          alu_take;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_rd;
  logic [DW-1:0] push_data;

  logic [DEPTH-1:0] entry_valid;
  logic [NR-1:0]    busy_vec;
  logic             hit;
  logic [DW-1:0]    hit_data;
  logic [PW-1:0]    scan_idx;

  // Readiness looks only at the registered occupancy, never at a same-cycle pop.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_ready = !full && !bus.flush;
  assign alu_ready = !full && !bus.flush && !bus.mem_valid;
  assign mem_take  = bus.mem_valid && mem_ready;
  assign alu_take  = bus.alu_valid && alu_ready;
  assign push_rd   = mem_take ? bus.mem_rd   : bus.alu_rd;
  assign push_data = mem_take ? bus.mem_data : bus.alu_data;
  assign push      = (mem_take || alu_take) && (push_rd != '0);
  assign pop       = !empty && !bus.stall && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we3_d    = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        we3_d    = 1'b1;
        a3_d     = rd_mem[rd_ptr_q];
        wd3_d    = data_mem[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= push_rd;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PW-1:0] age;
    assign age             = PW'(gi) - rd_ptr_q;
    assign entry_valid[gi] = ({1'b0, age} < count_q);
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy_vec[rd_mem[i]] = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int a = 0; a < DEPTH; a++) begin
      scan_idx = rd_ptr_q + PW'(a);
      if (entry_valid[scan_idx] && (bus.q_addr != '0) && (rd_mem[scan_idx] == bus.q_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[scan_idx];
      end
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.WE3       = we3_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
  assign bus.q_hit     = hit;
  assign bus.q_data    = hit_data;
  assign bus.busy      = busy_vec;
  assign bus.count     = count_q;
endmodule
